// File: rtl/riscv_dmem_responder.sv
// Single-port data memory responder with a fixed-latency req/rsp handshake.
// Ports: i_clk/i_rstn, i_dmem_req/o_dmem_ready, request fields, o_dmem_rd_data/o_dmem_rsp_valid/o_dmem_err.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_dmem_req,
  output logic                 o_dmem_ready,
  input  logic [`XLEN-1:0]     i_dmem_addr,
  input  logic                 i_dmem_wen,
  input  logic [`XLEN-1:0]     i_dmem_wr_data,
  input  logic [`XLEN/8-1:0]   i_dmem_byte_sel,
  output logic [`XLEN-1:0]     o_dmem_rd_data,
  output logic                 o_dmem_rsp_valid,
  output logic                 o_dmem_err
);

  localparam int XL    = `XLEN;
  localparam int NB    = XL / 8;
  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [XL-3:0]     addr_q;
  logic              wen_q;
  logic [XL-1:0]     wdata_q;
  logic [NB-1:0]     sel_q;
  logic [XL-1:0]     rd_data_q;
  logic              rsp_valid_q;
  logic              err_q;

  logic [XL-1:0]     mem_q [WORDS];

  logic              accept;
  logic              wait_done;
  logic              enter_resp;
  logic              use_in;
  logic [XL-3:0]     acc_word;
  logic              acc_wen;
  logic [XL-1:0]     acc_wdata;
  logic [NB-1:0]     acc_sel;
  logic [DEPTH_LOG2-1:0] idx;
  logic              oor;
  logic [XL-1:0]     rd_d;
  logic              unused_addr;

  // Byte offset bits never select anything.
  assign unused_addr = ^i_dmem_addr[1:0];

  assign o_dmem_ready = (state_q == IDLE);
  assign accept       = i_dmem_req && (state_q == IDLE);
  assign wait_done    = (state_q == WAIT) && (cnt_q <= 4'd1);
  assign enter_resp   = (accept && (LATENCY == 0)) || wait_done;

  // With zero latency the access shares the accept edge, so the live
  // inputs stand in for the registers being loaded on that same edge.
  assign use_in    = (state_q == IDLE);
  assign acc_word  = use_in ? i_dmem_addr[XL-1:2] : addr_q;
  assign acc_wen   = use_in ? i_dmem_wen : wen_q;
  assign acc_wdata = use_in ? i_dmem_wr_data : wdata_q;
  assign acc_sel   = use_in ? i_dmem_byte_sel : sel_q;

  assign idx = acc_word[DEPTH_LOG2-1:0];
  assign oor = |acc_word[XL-3:DEPTH_LOG2];

  assign rd_d = (!acc_wen && !oor) ? mem_q[idx] : '0;

  // Array is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (i_rstn && enter_resp && acc_wen && !oor) begin
      for (int b = 0; b < NB; b++) begin
        if (acc_sel[b]) begin
          mem_q[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      sel_q       <= '0;
      rd_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rd_data_q   <= '0;
      unique case (state_q)
        IDLE: begin
          if (i_dmem_req) begin
            addr_q  <= i_dmem_addr[XL-1:2];
            wen_q   <= i_dmem_wen;
            wdata_q <= i_dmem_wr_data;
            sel_q   <= i_dmem_byte_sel;
            if (LATENCY == 0) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              err_q       <= oor;
              rd_data_q   <= rd_d;
            end else begin
              state_q <= WAIT;
              cnt_q   <= LAT;
            end
          end
        end
        WAIT: begin
          if (wait_done) begin
            state_q     <= RESP;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b1;
            err_q       <= oor;
            rd_data_q   <= rd_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_dmem_rd_data   = rd_data_q;
  assign o_dmem_rsp_valid = rsp_valid_q;
  assign o_dmem_err       = err_q;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed bench for riscv_dmem_responder.
// Instances: LATENCY=2 (main) and LATENCY=0.
`ifndef XLEN
`define XLEN 32
`endif

module tb_riscv_dmem_responder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req2, req0;
  logic [31:0] addr;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  bsel;

  logic        rdy2, rsp2, err2;
  logic [31:0] rd2;
  logic        rdy0, rsp0, err0;
  logic [31:0] rd0;

  logic        use0;
  logic        rdy_m, rsp_m, err_m;
  logic [31:0] rd_m;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign rdy_m = use0 ? rdy0 : rdy2;
  assign rsp_m = use0 ? rsp0 : rsp2;
  assign err_m = use0 ? err0 : err2;
  assign rd_m  = use0 ? rd0 : rd2;

  riscv_dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) u_dut2 (
    .i_clk           (clk),
    .i_rstn          (rstn),
    .i_dmem_req      (req2),
    .o_dmem_ready    (rdy2),
    .i_dmem_addr     (addr),
    .i_dmem_wen      (wen),
    .i_dmem_wr_data  (wdata),
    .i_dmem_byte_sel (bsel),
    .o_dmem_rd_data  (rd2),
    .o_dmem_rsp_valid(rsp2),
    .o_dmem_err      (err2)
  );

  riscv_dmem_responder #(.DEPTH_LOG2(10), .LATENCY(0)) u_dut0 (
    .i_clk           (clk),
    .i_rstn          (rstn),
    .i_dmem_req      (req0),
    .o_dmem_ready    (rdy0),
    .i_dmem_addr     (addr),
    .i_dmem_wen      (wen),
    .i_dmem_wr_data  (wdata),
    .i_dmem_byte_sel (bsel),
    .o_dmem_rd_data  (rd0),
    .o_dmem_rsp_valid(rsp0),
    .o_dmem_err      (err0)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one request, returns response data, latency (cycles from the
  // accept cycle to rsp_valid) and number of cycles ready stayed low.
  task automatic txn(input bit d0, input logic [31:0] a, input logic w,
                     input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output logic e,
                     output int lat, output int lowc);
    use0 = d0;
    @(posedge clk); #1;
    addr = a; wen = w; wdata = d; bsel = s;
    if (d0) req0 = 1'b1; else req2 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0; req2 = 1'b0;
    lat = -1; lowc = 0; rd = '0; e = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (!rdy_m) lowc++;
      if (rsp_m && lat < 0) begin
        lat = k; rd = rd_m; e = err_m;
      end
      if (lat >= 0 && rdy_m) break;
    end
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat, lowc;
  int          na, nr;
  int          acc[4];
  int          rsc[4];

  initial begin
    rstn = 1'b0; req2 = 1'b0; req0 = 1'b0; use0 = 1'b0;
    addr = '0; wen = 1'b0; wdata = '0; bsel = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(rdy2), 32'd1);
    chk("rst_rsp", 32'(rsp2), 32'd0);
    chk("rst_err", 32'(err2), 32'd0);
    chk("rst_rd", rd2, 32'h0);
    chk("rst_ready0", 32'(rdy0), 32'd1);
    rstn = 1'b1;

    txn(0, 32'h10, 1, 32'hDEADBEEF, 4'hF, rd, e, lat, lowc);
    chk("wr_lat", 32'(lat), 32'd3);
    chk("wr_low", 32'(lowc), 32'd3);
    chk("wr_err", 32'(e), 32'd0);
    chk("wr_rd", rd, 32'h0);

    txn(0, 32'h10, 0, 32'h0, 4'h0, rd, e, lat, lowc);
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_low", 32'(lowc), 32'd3);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_err", 32'(e), 32'd0);
    chk("rd_clr_valid", 32'(rsp2), 32'd0);
    chk("rd_clr_data", rd2, 32'h0);

    txn(0, 32'h12, 1, 32'h00AA0000, 4'b0100, rd, e, lat, lowc);
    txn(0, 32'h10, 0, 32'h0, 4'h0, rd, e, lat, lowc);
    chk("lane_data", rd, 32'hDEAABEEF);

    txn(0, 32'h10, 1, 32'hFFFFFFFF, 4'b0000, rd, e, lat, lowc);
    chk("sel0_lat", 32'(lat), 32'd3);
    chk("sel0_err", 32'(e), 32'd0);
    txn(0, 32'h10, 0, 32'h0, 4'h0, rd, e, lat, lowc);
    chk("sel0_data", rd, 32'hDEAABEEF);

    // Request held high across two reads.
    use0 = 1'b0;
    @(posedge clk); #1;
    addr = 32'h10; wen = 1'b0; bsel = 4'h0; req2 = 1'b1;
    na = 0; nr = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (rdy2 && req2) begin
        if (na < 4) acc[na] = c;
        na++;
      end
      if (rsp2) begin
        if (nr < 4) rsc[nr] = c;
        nr++;
      end
      @(posedge clk); #1;
      if (na >= 2) req2 = 1'b0;
    end
    req2 = 1'b0;
    chk("b2b_accepts", 32'(na), 32'd2);
    chk("b2b_pulses", 32'(nr), 32'd2);
    if (na >= 2 && nr >= 2) begin
      chk("b2b_acc_gap", 32'(acc[1] - acc[0]), 32'd4);
      chk("b2b_rsp_gap", 32'(rsc[1] - rsc[0]), 32'd4);
      chk("b2b_first_lat", 32'(rsc[0] - acc[0]), 32'd3);
    end

    txn(0, 32'h0, 1, 32'hCAFEF00D, 4'hF, rd, e, lat, lowc);
    txn(0, 32'h1000, 1, 32'h12345678, 4'hF, rd, e, lat, lowc);
    chk("oor_lat", 32'(lat), 32'd3);
    chk("oor_err", 32'(e), 32'd1);
    chk("oor_rd", rd, 32'h0);
    chk("oor_err_clr", 32'(err2), 32'd0);
    txn(0, 32'h0, 0, 32'h0, 4'h0, rd, e, lat, lowc);
    chk("oor_word0", rd, 32'hCAFEF00D);
    chk("oor_word0_err", 32'(e), 32'd0);
    txn(0, 32'h2000, 0, 32'h0, 4'h0, rd, e, lat, lowc);
    chk("oor_rd_err", 32'(e), 32'd1);
    chk("oor_rd_data", rd, 32'h0);

    // Reset during WAIT aborts the write.
    txn(0, 32'h20, 1, 32'h0, 4'hF, rd, e, lat, lowc);
    use0 = 1'b0;
    @(posedge clk); #1;
    addr = 32'h20; wen = 1'b1; wdata = 32'h55; bsel = 4'hF; req2 = 1'b1;
    @(posedge clk); #1;
    req2 = 1'b0;
    @(negedge clk);
    chk("abort_in_wait", 32'(rdy2), 32'd0);
    rstn = 1'b0;
    #1;
    chk("abort_ready", 32'(rdy2), 32'd1);
    chk("abort_rsp", 32'(rsp2), 32'd0);
    chk("abort_err", 32'(err2), 32'd0);
    chk("abort_rd", rd2, 32'h0);
    na = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp2) na++;
    end
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rsp2) na++;
    end
    chk("abort_no_rsp", 32'(na), 32'd0);
    txn(0, 32'h20, 0, 32'h0, 4'h0, rd, e, lat, lowc);
    chk("abort_mem", rd, 32'h0);

    // Zero-latency instance.
    txn(1, 32'h10, 1, 32'h11223344, 4'hF, rd, e, lat, lowc);
    chk("l0_wr_lat", 32'(lat), 32'd1);
    txn(1, 32'h10, 0, 32'h0, 4'h0, rd, e, lat, lowc);
    chk("l0_rd_lat", 32'(lat), 32'd1);
    chk("l0_rd_low", 32'(lowc), 32'd1);
    chk("l0_rd_data", rd, 32'h11223344);
    chk("l0_rd_clr", rd0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
